// File: rtl/sched_if.sv
// Request/control bundle between the ID/MEM stages and the pipeline scheduler.
// The master drives the stage requests; the scheduler is the slave.
interface sched_if;
    logic        schi_pause_request;
    logic [3:0]  schi_sched_count;
    logic        schi_mem_conflict;
    logic        schi_branch;
    logic [15:0] schi_branch_pc;
    logic        schi_sw_int;
    logic [3:0]  schi_sw_int_id;
    logic        schi_hw_int;
    logic [3:0]  schi_hw_int_id;
    logic        schi_int_enable;
    logic        schi_int_disable;
    logic [15:0] schi_id_pc;

    logic        scho_pc_stall;
    logic        scho_ifid_stall;
    logic        scho_ifid_flush;
    logic        scho_idex_flush;
    logic        scho_pc_load;
    logic [15:0] scho_pc_target;
    logic        scho_int_en;
    logic [7:0]  scho_cause;
    logic [15:0] scho_epc;
    logic [1:0]  scho_state;

    modport master (
        output schi_pause_request, schi_sched_count, schi_mem_conflict, schi_branch,
               schi_branch_pc, schi_sw_int, schi_sw_int_id, schi_hw_int, schi_hw_int_id,
               schi_int_enable, schi_int_disable, schi_id_pc,
        input  scho_pc_stall, scho_ifid_stall, scho_ifid_flush, scho_idex_flush,
               scho_pc_load, scho_pc_target, scho_int_en, scho_cause, scho_epc, scho_state
    );

    modport slave (
        input  schi_pause_request, schi_sched_count, schi_mem_conflict, schi_branch,
               schi_branch_pc, schi_sw_int, schi_sw_int_id, schi_hw_int, schi_hw_int_id,
               schi_int_enable, schi_int_disable, schi_id_pc,
        output scho_pc_stall, scho_ifid_stall, scho_ifid_flush, scho_idex_flush,
               scho_pc_load, scho_pc_target, scho_int_en, scho_cause, scho_epc, scho_state
    );
endinterface

// File: rtl/sched_ctrl.sv
// Pipeline scheduler for the 16-bit five-stage core: stall/flush/redirect
// control plus interrupt entry, drain and ERET sequencing.
module sched_ctrl #(
    parameter logic [15:0] HANDLER_ADDR = 16'h0008,
    parameter int unsigned INT_DRAIN    = 3
) (
    input  logic   clk,
    input  logic   rst,
    sched_if.slave sif
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        DRAIN = 2'd2,
        JUMP  = 2'd3
    } state_t;

    localparam logic [3:0] DRAIN_INIT = 4'(INT_DRAIN - 1);
    // The RUN cycle that takes the interrupt is the first drain cycle, so a
    // one-cycle drain goes straight to the handler jump.
    localparam bit DRAIN_SKIP = (INT_DRAIN <= 1);

    state_t      state;
    logic [3:0]  counter;
    logic        int_en;
    logic [7:0]  cause;
    logic [15:0] epc;

    logic hw_take, sw_take, int_take, eret;

    assign hw_take  = sif.schi_hw_int & int_en;
    assign sw_take  = sif.schi_sw_int & (sif.schi_sw_int_id != 4'hF);
    assign int_take = hw_take | sw_take;
    assign eret     = sif.schi_sw_int & (sif.schi_sw_int_id == 4'hF) & ~hw_take;

    assign sif.scho_int_en = int_en;
    assign sif.scho_cause  = cause;
    assign sif.scho_epc    = epc;
    assign sif.scho_state  = state;

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        sif.scho_pc_stall   = 1'b0;
        sif.scho_ifid_stall = 1'b0;
        sif.scho_ifid_flush = 1'b0;
        sif.scho_idex_flush = 1'b0;
        sif.scho_pc_load    = 1'b0;
        sif.scho_pc_target  = 16'h0000;
        if (rst) begin
            unique case (state)
                RUN: begin
                    if (int_take) begin
                        sif.scho_pc_stall   = 1'b1;
                        sif.scho_ifid_flush = 1'b1;
                        sif.scho_idex_flush = 1'b1;
                    end else if (eret) begin
                        sif.scho_pc_load    = 1'b1;
                        sif.scho_pc_target  = epc;
                        sif.scho_ifid_flush = 1'b1;
                    end else if (sif.schi_pause_request ||
                                 (sif.schi_branch && sif.schi_mem_conflict)) begin
                        sif.scho_pc_stall   = 1'b1;
                        sif.scho_ifid_stall = 1'b1;
                        sif.scho_idex_flush = 1'b1;
                    end else if (sif.schi_branch) begin
                        sif.scho_pc_load    = 1'b1;
                        sif.scho_pc_target  = sif.schi_branch_pc;
                    end else if (sif.schi_mem_conflict) begin
                        sif.scho_pc_stall   = 1'b1;
                        sif.scho_ifid_flush = 1'b1;
                    end
                end
                STALL: begin
                    sif.scho_pc_stall   = 1'b1;
                    sif.scho_ifid_stall = 1'b1;
                    sif.scho_idex_flush = 1'b1;
                end
                DRAIN: begin
                    sif.scho_pc_stall   = 1'b1;
                    sif.scho_ifid_flush = 1'b1;
                end
                JUMP: begin
                    sif.scho_pc_load    = 1'b1;
                    sif.scho_pc_target  = HANDLER_ADDR;
                    sif.scho_ifid_flush = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= RUN;
            counter <= 4'd0;
            int_en  <= 1'b0;
            cause   <= 8'h00;
            epc     <= 16'h0000;
        end else begin
            unique case (state)
                RUN: begin
                    if (int_take) begin
                        epc     <= hw_take ? sif.schi_id_pc : sif.schi_id_pc + 16'd1;
                        cause   <= hw_take ? {1'b1, 3'b000, sif.schi_hw_int_id}
                                           : {1'b0, 3'b000, sif.schi_sw_int_id};
                        int_en  <= 1'b0;
                        counter <= DRAIN_INIT;
                        state   <= DRAIN_SKIP ? JUMP : DRAIN;
                    end else if (eret) begin
                        int_en <= 1'b1;
                    end else begin
                        if (sif.schi_int_disable)     int_en <= 1'b0;
                        else if (sif.schi_int_enable) int_en <= 1'b1;
                        // The RUN cycle is the first bubble and STALL exits on
                        // counter==0, so count-2 yields count bubbles in total.
                        if (sif.schi_pause_request && sif.schi_sched_count > 4'd1) begin
                            counter <= sif.schi_sched_count - 4'd2;
                            state   <= STALL;
                        end
                    end
                end
                STALL: begin
                    if (counter == 4'd0) state <= RUN;
                    else                 counter <= counter - 4'd1;
                end
                DRAIN: begin
                    if (counter <= 4'd1) begin
                        counter <= 4'd0;
                        state   <= JUMP;
                    end else begin
                        counter <= counter - 4'd1;
                    end
                end
                JUMP: state <= RUN;
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_sched_ctrl.sv
// Randomized scoreboard bench for sched_ctrl: a queue-of-pending-actions model
// predicts each cycle's controls, and a separate monitor compares them.
module tb_sched_ctrl;

    localparam logic [15:0] HANDLER   = 16'h0008;
    localparam int          INT_DRAIN = 3;

    typedef struct {
        logic        rst;
        logic        pause;
        logic [3:0]  count;
        logic        conflict;
        logic        branch;
        logic [15:0] bpc;
        logic        sw;
        logic [3:0]  sw_id;
        logic        hw;
        logic [3:0]  hw_id;
        logic        en;
        logic        dis;
        logic [15:0] id_pc;
    } in_t;

    typedef struct packed {
        logic        pc_stall;
        logic        ifid_stall;
        logic        ifid_flush;
        logic        idex_flush;
        logic        pc_load;
        logic [15:0] target;
        logic        int_en;
        logic [7:0]  cause;
        logic [15:0] epc;
        logic [1:0]  state;
    } out_t;

    typedef struct {
        out_t v;
        bit   chk_target;
        int   cyc;
    } sb_t;

    typedef enum {A_STALL, A_DRAIN, A_JUMP} act_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    sched_if sif ();

    sched_ctrl #(.HANDLER_ADDR(HANDLER), .INT_DRAIN(INT_DRAIN)) dut (
        .clk (clk),
        .rst (rst),
        .sif (sif)
    );

    always #5 clk = ~clk;

    sb_t   sb[$];
    act_t  pend[$];
    logic        m_int_en = 1'b0;
    logic [15:0] m_epc    = 16'h0000;
    logic [7:0]  m_cause  = 8'h00;
    int    cyc_n    = 0;
    bit    drv_done = 0;
    int    total    = 0;
    int    bad      = 0;

    function automatic in_t idle_in();
        in_t s;
        s = '{rst: 1'b1, pause: 1'b0, count: 4'd0, conflict: 1'b0, branch: 1'b0,
              bpc: 16'h0, sw: 1'b0, sw_id: 4'd0, hw: 1'b0, hw_id: 4'd0,
              en: 1'b0, dis: 1'b0, id_pc: 16'h0};
        return s;
    endfunction

    // Reference model: in-flight sequences are a list of future forced cycles.
    task automatic model_step(input in_t s);
        sb_t  e;
        act_t a;
        bit   hw_t, sw_t;
        int   n;
        e.v = '0;
        e.chk_target = 1'b0;
        e.cyc = cyc_n;
        if (!s.rst) begin
            m_int_en = 1'b0;
            m_epc    = 16'h0;
            m_cause  = 8'h0;
            pend.delete();
            e.chk_target = 1'b1;
        end else begin
            e.v.int_en = m_int_en;
            e.v.epc    = m_epc;
            e.v.cause  = m_cause;
            if (pend.size() > 0) begin
                a = pend.pop_front();
                case (a)
                    A_STALL: begin
                        e.v.state = 2'd1;
                        e.v.pc_stall = 1'b1; e.v.ifid_stall = 1'b1; e.v.idex_flush = 1'b1;
                    end
                    A_DRAIN: begin
                        e.v.state = 2'd2;
                        e.v.pc_stall = 1'b1; e.v.ifid_flush = 1'b1;
                    end
                    default: begin
                        e.v.state = 2'd3;
                        e.v.pc_load = 1'b1; e.v.target = HANDLER; e.v.ifid_flush = 1'b1;
                        e.chk_target = 1'b1;
                    end
                endcase
            end else begin
                e.v.state = 2'd0;
                hw_t = s.hw && m_int_en;
                sw_t = s.sw && (s.sw_id != 4'hF);
                if (hw_t || sw_t) begin
                    e.v.pc_stall = 1'b1; e.v.ifid_flush = 1'b1; e.v.idex_flush = 1'b1;
                    m_epc    = hw_t ? s.id_pc : 16'(s.id_pc + 16'd1);
                    m_cause  = hw_t ? {1'b1, 3'b000, s.hw_id} : {4'b0000, s.sw_id};
                    m_int_en = 1'b0;
                    repeat (INT_DRAIN - 1) pend.push_back(A_DRAIN);
                    pend.push_back(A_JUMP);
                end else if (s.sw) begin
                    e.v.pc_load = 1'b1; e.v.target = m_epc; e.v.ifid_flush = 1'b1;
                    e.chk_target = 1'b1;
                    m_int_en = 1'b1;
                end else begin
                    if (s.dis)     m_int_en = 1'b0;
                    else if (s.en) m_int_en = 1'b1;
                    if (s.pause) begin
                        e.v.pc_stall = 1'b1; e.v.ifid_stall = 1'b1; e.v.idex_flush = 1'b1;
                        n = (s.count == 4'd0) ? 1 : int'(s.count);
                        repeat (n - 1) pend.push_back(A_STALL);
                    end else if (s.branch && s.conflict) begin
                        e.v.pc_stall = 1'b1; e.v.ifid_stall = 1'b1; e.v.idex_flush = 1'b1;
                    end else if (s.branch) begin
                        e.v.pc_load = 1'b1; e.v.target = s.bpc;
                        e.chk_target = 1'b1;
                    end else if (s.conflict) begin
                        e.v.pc_stall = 1'b1; e.v.ifid_flush = 1'b1;
                    end
                end
            end
        end
        sb.push_back(e);
    endtask

    task automatic drive_cycle(input in_t s);
        @(negedge clk);
        rst                    = s.rst;
        sif.schi_pause_request = s.pause;
        sif.schi_sched_count   = s.count;
        sif.schi_mem_conflict  = s.conflict;
        sif.schi_branch        = s.branch;
        sif.schi_branch_pc     = s.bpc;
        sif.schi_sw_int        = s.sw;
        sif.schi_sw_int_id     = s.sw_id;
        sif.schi_hw_int        = s.hw;
        sif.schi_hw_int_id     = s.hw_id;
        sif.schi_int_enable    = s.en;
        sif.schi_int_disable   = s.dis;
        sif.schi_id_pc         = s.id_pc;
        model_step(s);
        cyc_n++;
    endtask

    task automatic idle(input int n);
        repeat (n) drive_cycle(idle_in());
    endtask

    // Stimulus: directed scenarios first, then constrained-random traffic.
    initial begin
        in_t s;
        s = '{rst: 1'b0, pause: 1'b1, count: 4'hF, conflict: 1'b1, branch: 1'b1,
              bpc: 16'hFFFF, sw: 1'b1, sw_id: 4'hF, hw: 1'b1, hw_id: 4'hF,
              en: 1'b1, dis: 1'b1, id_pc: 16'hFFFF};
        repeat (3) drive_cycle(s);
        idle(2);

        s = idle_in(); s.pause = 1'b1; s.count = 4'd3; drive_cycle(s); idle(3);
        s = idle_in(); s.pause = 1'b1; s.count = 4'd0; drive_cycle(s); idle(2);

        s = idle_in(); s.branch = 1'b1; s.bpc = 16'h1234; drive_cycle(s); idle(1);
        s = idle_in(); s.branch = 1'b1; s.bpc = 16'h2222; s.conflict = 1'b1; drive_cycle(s);
        s.conflict = 1'b0; drive_cycle(s); idle(1);

        s = idle_in(); s.en = 1'b1; drive_cycle(s);
        s = idle_in(); s.sw = 1'b1; s.sw_id = 4'd5; s.id_pc = 16'h0040; drive_cycle(s); idle(4);

        s = idle_in(); s.en = 1'b1; drive_cycle(s);
        s = idle_in(); s.hw = 1'b1; s.hw_id = 4'd3; s.sw = 1'b1; s.sw_id = 4'd1;
        s.id_pc = 16'h0100; drive_cycle(s); idle(4);
        s = idle_in(); s.sw = 1'b1; s.sw_id = 4'hF; drive_cycle(s); idle(1);

        s = idle_in(); s.sw = 1'b1; s.sw_id = 4'd2; s.id_pc = 16'hFFFF; drive_cycle(s); idle(4);

        s = idle_in(); s.en = 1'b1; s.dis = 1'b1; drive_cycle(s);
        s = idle_in(); s.hw = 1'b1; s.hw_id = 4'd2; drive_cycle(s); idle(2);

        for (int i = 0; i < 3000; i++) begin
            s.rst      = ($urandom_range(0, 149) != 0);
            s.pause    = ($urandom_range(0, 9) == 0);
            s.count    = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'($urandom_range(0, 4));
            s.conflict = ($urandom_range(0, 4) == 0);
            s.branch   = ($urandom_range(0, 4) == 0);
            s.bpc      = 16'($urandom);
            s.sw       = ($urandom_range(0, 19) == 0);
            s.sw_id    = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom);
            s.hw       = ($urandom_range(0, 9) == 0);
            s.hw_id    = 4'($urandom);
            s.en       = ($urandom_range(0, 7) == 0);
            s.dis      = ($urandom_range(0, 15) == 0);
            s.id_pc    = ($urandom_range(0, 31) == 0) ? 16'hFFFF : 16'($urandom);
            drive_cycle(s);
        end
        idle(20);
        drv_done = 1;
    end

    // Monitor: compares the combinational controls just before each rising edge.
    initial begin
        sb_t  e;
        out_t got, exp_v;
        for (int k = 0; k < 20000; k++) begin
            @(negedge clk);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                got = '{pc_stall: sif.scho_pc_stall, ifid_stall: sif.scho_ifid_stall,
                        ifid_flush: sif.scho_ifid_flush, idex_flush: sif.scho_idex_flush,
                        pc_load: sif.scho_pc_load, target: sif.scho_pc_target,
                        int_en: sif.scho_int_en, cause: sif.scho_cause,
                        epc: sif.scho_epc, state: sif.scho_state};
                exp_v = e.v;
                if (!e.chk_target) begin
                    got.target   = 16'h0;
                    exp_v.target = 16'h0;
                end
                total++;
                if (got !== exp_v) begin
                    bad++;
                    $display("FAIL controls cyc=%0d got=%h expected=%h", e.cyc, got, exp_v);
                end
            end else if (drv_done) begin
                break;
            end
        end
        if (!drv_done || sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL run_bound cyc=%0d pending=%0d expected=0", cyc_n, sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
